// File: rtl/spi_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile_if
// Four-wire SPI bus between a master driver and the register endpoint.
//   spi_sclk_i  : SPI clock, driven by the master
//   spi_cs_i    : chip select, active-low, driven by the master
//   spi_mosi_i  : master-out data
//   spi_miso_o  : slave-out data
// The master modport drives clock, select and MOSI; the slave drives MISO.
// ---------------------------------------------------------------------------
interface spi_slave_regfile_if;
    logic spi_sclk_i;
    logic spi_cs_i;
    logic spi_mosi_i;
    logic spi_miso_o;

    modport master (
        output spi_sclk_i,
        output spi_cs_i,
        output spi_mosi_i,
        input  spi_miso_o
    );

    modport slave (
        input  spi_sclk_i,
        input  spi_cs_i,
        input  spi_mosi_i,
        output spi_miso_o
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile
// SPI mode-0 slave exposing seven 8-bit registers plus a read-only status
// byte at address 7. Each frame is a command byte (bit7 = write, bits 2:0 =
// start address) followed by one or more data bytes. The address
// auto-increments modulo 8 after every data byte. While the command byte is
// shifting in, the slave returns an identification byte.
// Ports:
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   spi          : SPI bus (slave modport), oversampled by clk_i
//   status_i     : value returned for reads of address 7
//   regs_o       : registers 0..6 packed, reg n at bits [8n+7:8n]
//   wr_o         : one-cycle write strobe, with wr_addr_o / wr_data_o
//   busy_o       : high while a frame is in progress
// ---------------------------------------------------------------------------
module spi_slave_regfile (
    input  logic                 clk_i,
    input  logic                 rst_i,
    spi_slave_regfile_if.slave   spi,
    input  logic [7:0]           status_i,
    output logic [55:0]          regs_o,
    output logic                 wr_o,
    output logic [2:0]           wr_addr_o,
    output logic [7:0]           wr_data_o,
    output logic                 busy_o
);

    localparam logic [7:0] ID_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t           state;
    logic [1:0]       sclk_sync;
    logic [1:0]       cs_sync;
    logic [1:0]       mosi_sync;
    logic             sclk_prev;
    logic             cs_prev;
    logic [2:0]       bit_cnt;
    logic [6:0]       shift_in;
    logic [7:0]       shift_out;
    logic             miso_q;
    logic             is_write;
    logic [2:0]       addr;
    logic [6:0][7:0]  regs_q;

    logic             sclk_s;
    logic             cs_s;
    logic             mosi_s;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             cs_rise;
    logic             cs_fall;

    // Read port shared by the command and data paths: address 7 is the
    // external status byte, everything else comes from the register file.
    function automatic logic [7:0] read_value(input logic [2:0] a);
        if (a == 3'd7)
            return status_i;
        else
            return regs_q[a];
    endfunction

    // Two-flop synchronizers for all three SPI inputs, plus one more stage
    // of history on SCLK and CS for edge detection. MOSI passes through the
    // same depth as SCLK, so the synced data bit lines up with the synced
    // rising edge. CS history resets to 0: if CS is already low when reset
    // releases, no fall is seen and the slave stays idle until a fresh frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.spi_sclk_i};
            cs_sync   <= {cs_sync[0], spi.spi_cs_i};
            mosi_sync <= {mosi_sync[0], spi.spi_mosi_i};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Frame state machine. CS edges take priority over SCLK edges, so an
    // SCLK rise that coincides with the CS fall is not counted. The outgoing
    // shift register always holds the bits still to be sent below the one
    // currently on MISO; on CS fall the ID byte's MSB goes out at once and
    // its remaining bits are kept pre-shifted. A byte loaded at byte-complete
    // is shifted out starting with the following SCLK fall. On the last bit
    // of each data byte the write is committed and the next address is
    // pre-read, so reads after a write in the same frame see the new value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            miso_q    <= 1'b0;
            is_write  <= 1'b0;
            addr      <= 3'd0;
            regs_q    <= '0;
            wr_o      <= 1'b0;
            wr_addr_o <= 3'd0;
            wr_data_o <= 8'd0;
        end else begin
            wr_o <= 1'b0;
            if (cs_rise) begin
                state   <= IDLE;
                bit_cnt <= 3'd0;
                miso_q  <= 1'b0;
            end else if (cs_fall) begin
                state     <= CMD;
                bit_cnt   <= 3'd0;
                shift_out <= {ID_BYTE[6:0], 1'b0};
                miso_q    <= ID_BYTE[7];
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    shift_in <= {shift_in[5:0], mosi_s};
                    if (bit_cnt == 3'd7) begin
                        if (state == CMD) begin
                            state     <= DATA;
                            is_write  <= shift_in[6];
                            addr      <= {shift_in[1:0], mosi_s};
                            shift_out <= read_value({shift_in[1:0], mosi_s});
                        end else begin
                            if (is_write) begin
                                wr_o      <= 1'b1;
                                wr_addr_o <= addr;
                                wr_data_o <= {shift_in, mosi_s};
                                if (addr != 3'd7)
                                    regs_q[addr] <= {shift_in, mosi_s};
                            end
                            addr      <= addr + 3'd1;
                            shift_out <= read_value(addr + 3'd1);
                        end
                    end
                end else if (sclk_fall) begin
                    miso_q    <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign spi.spi_miso_o = miso_q;
    assign regs_o         = regs_q;
    assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_regfile
// Drives SPI frames into spi_slave_regfile, captures the bytes returned on
// MISO and the write strobes, and compares both against a byte-level model
// of the register file kept in this bench.
// ---------------------------------------------------------------------------
module tb_spi_slave_regfile;

    logic        clk;
    logic        rst;
    logic [7:0]  status;
    logic [55:0] regs_o;
    logic        wr_o;
    logic [2:0]  wr_addr_o;
    logic [7:0]  wr_data_o;
    logic        busy_o;

    spi_slave_regfile_if bus ();

    spi_slave_regfile dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .spi       (bus),
        .status_i  (status),
        .regs_o    (regs_o),
        .wr_o      (wr_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy_o    (busy_o)
    );

    int          errors = 0;
    int          checks = 0;

    logic [7:0]  tx_bytes [0:7];
    logic [7:0]  rx_bytes [0:7];
    logic [7:0]  exp_rx   [0:7];
    logic [7:0]  model_regs [0:6];
    logic [10:0] got_wr [$];
    logic [10:0] exp_wr [$];
    logic [7:0]  scratch;

    // Free-running system clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every cycle in which the write strobe is high; a strobe stuck
    // for more than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (wr_o)
            got_wr.push_back({wr_addr_o, wr_data_o});
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [55:0] pack_model();
        logic [55:0] v;
        v = '0;
        for (int n = 0; n < 7; n++)
            v[8*n +: 8] = model_regs[n];
        return v;
    endfunction

    // Master side of one byte in mode 0: data set while SCLK is low, MISO
    // captured just before the rising edge, SCLK half period of 5 cycles.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.spi_mosi_i = tx[i];
            repeat (5) @(negedge clk);
            rx[i] = bus.spi_miso_o;
            bus.spi_sclk_i = 1'b1;
            repeat (5) @(negedge clk);
            bus.spi_sclk_i = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs_i = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("busy_in_frame", 64'(busy_o), 64'd1);
    endtask

    task automatic cs_high();
        repeat (5) @(negedge clk);
        bus.spi_cs_i = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("busy_after_frame", 64'(busy_o), 64'd0);
        checkOutput("miso_after_frame", 64'(bus.spi_miso_o), 64'd0);
    endtask

    // Byte-level model: the first returned byte is the ID; each full data
    // byte returns the current value at the running address, then (for a
    // write) stores into the model and expects a strobe, then the address
    // advances modulo 8.
    task automatic model_frame(input int nfull);
        int a;
        exp_wr.delete();
        exp_rx[0] = 8'hA5;
        a = int'(tx_bytes[0][2:0]);
        for (int i = 1; i < nfull; i++) begin
            exp_rx[i] = (a == 7) ? status : model_regs[a];
            if (tx_bytes[0][7]) begin
                exp_wr.push_back({3'(a), tx_bytes[i]});
                if (a != 7)
                    model_regs[a] = tx_bytes[i];
            end
            a = (a + 1) % 8;
        end
    endtask

    // Runs one frame of nbytes (the last one cut to last_bits bits) and
    // checks returned bytes, write strobes and the register outputs.
    task automatic applyStimulus(input int nbytes, input int last_bits);
        int nfull;
        int nmin;
        got_wr.delete();
        cs_low();
        for (int i = 0; i < nbytes; i++)
            spi_byte(tx_bytes[i], (i == nbytes - 1) ? last_bits : 8, rx_bytes[i]);
        cs_high();
        nfull = (last_bits == 8) ? nbytes : nbytes - 1;
        model_frame(nfull);
        for (int i = 0; i < nfull; i++)
            checkOutput($sformatf("miso_byte%0d", i), 64'(rx_bytes[i]), 64'(exp_rx[i]));
        checkOutput("wr_count", 64'(got_wr.size()), 64'(exp_wr.size()));
        nmin = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < nmin; i++)
            checkOutput($sformatf("wr_addr_data%0d", i), 64'(got_wr[i]), 64'(exp_wr[i]));
        checkOutput("regs_o", 64'(regs_o), 64'(pack_model()));
    endtask

    initial begin
        bus.spi_sclk_i = 1'b0;
        bus.spi_cs_i   = 1'b1;
        bus.spi_mosi_i = 1'b0;
        status         = 8'h00;
        rst            = 1'b1;
        for (int n = 0; n < 7; n++)
            model_regs[n] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_regs_o", 64'(regs_o), 64'd0);
        checkOutput("rst_wr_o", 64'(wr_o), 64'd0);
        checkOutput("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        checkOutput("rst_wr_data", 64'(wr_data_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_miso", 64'(bus.spi_miso_o), 64'd0);

        $display("[TB] write 0x3C to address 2");
        tx_bytes[0] = 8'h82; tx_bytes[1] = 8'h3C;
        applyStimulus(2, 8);
        checkOutput("reg2_value", 64'(regs_o[23:16]), 64'h3C);

        $display("[TB] read address 2");
        tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h00;
        applyStimulus(2, 8);
        checkOutput("read_back_reg2", 64'(rx_bytes[1]), 64'h3C);

        $display("[TB] burst write from address 6 with wrap");
        tx_bytes[0] = 8'h86; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22; tx_bytes[3] = 8'h33;
        applyStimulus(4, 8);
        checkOutput("reg6_value", 64'(regs_o[55:48]), 64'h11);
        checkOutput("reg0_value", 64'(regs_o[7:0]), 64'h33);

        $display("[TB] read status at address 7");
        status = 8'h5A;
        tx_bytes[0] = 8'h07; tx_bytes[1] = 8'h00;
        applyStimulus(2, 8);
        checkOutput("status_read", 64'(rx_bytes[1]), 64'h5A);

        $display("[TB] partial data byte discarded");
        tx_bytes[0] = 8'h81; tx_bytes[1] = 8'hE7;
        applyStimulus(2, 4);
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h00;
        applyStimulus(2, 8);
        checkOutput("reg1_unchanged", 64'(rx_bytes[1]), 64'h00);

        $display("[TB] reset in the middle of a data byte");
        got_wr.delete();
        cs_low();
        spi_byte(8'h84, 8, scratch);
        spi_byte(8'hF0, 4, scratch);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_regs_o", 64'(regs_o), 64'd0);
        checkOutput("midrst_wr_o", 64'(wr_o), 64'd0);
        checkOutput("midrst_wr_addr", 64'(wr_addr_o), 64'd0);
        checkOutput("midrst_wr_data", 64'(wr_data_o), 64'd0);
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_miso", 64'(bus.spi_miso_o), 64'd0);
        rst = 1'b0;
        for (int n = 0; n < 7; n++)
            model_regs[n] = 8'h00;
        spi_byte(8'hF0, 4, scratch);
        spi_byte(8'h99, 8, scratch);
        checkOutput("ignored_after_rst_busy", 64'(busy_o), 64'd0);
        repeat (5) @(negedge clk);
        bus.spi_cs_i = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("ignored_after_rst_wr", 64'(got_wr.size()), 64'd0);
        checkOutput("ignored_after_rst_regs", 64'(regs_o), 64'd0);

        $display("[TB] clean write after reset");
        tx_bytes[0] = 8'h85; tx_bytes[1] = 8'hC3; tx_bytes[2] = 8'h7E;
        applyStimulus(3, 8);
        tx_bytes[0] = 8'h05; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
        applyStimulus(3, 8);

        $display("[TB] randomized frames");
        for (int k = 0; k < 12; k++) begin
            int nb;
            status = 8'($urandom);
            nb = 1 + int'($urandom_range(1, 5));
            for (int i = 0; i < nb; i++)
                tx_bytes[i] = 8'($urandom);
            applyStimulus(nb, 8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
